// File: rtl/rob_buf_pkg.sv
// Shared types and default sizes for the reorder buffer.
// Tags index slots; pointers carry an extra wrap bit.
package rob_buf_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_AWIDTH = 3;
    localparam int DEF_WIDTH  = 34;

    typedef logic [DEF_AWIDTH-1:0] tag_t;
    typedef logic [DEF_AWIDTH:0]   ptr_t;

    // Index bits of a wrap-extended pointer.
    function automatic tag_t ptr_idx(input ptr_t p);
        return p[DEF_AWIDTH-1:0];
    endfunction

endpackage

// File: rtl/rob_store.sv
// Reorder buffer slot storage: payload array plus per-slot
// allocated/completed bits, registered writes, array read.
module rob_store
    import rob_buf_pkg::*;
#(
    parameter int depth  = DEF_DEPTH,
    parameter int awidth = DEF_AWIDTH,
    parameter int width  = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              set_en,
    input  logic [awidth-1:0] set_idx,
    input  logic              done_en,
    input  logic [awidth-1:0] done_idx,
    input  logic [width-1:0]  done_data,
    input  logic              free_en,
    input  logic [awidth-1:0] free_idx,
    input  logic [awidth-1:0] rd_idx,
    output logic [width-1:0]  rd_data,
    output logic [depth-1:0]  alloc_bits,
    output logic [depth-1:0]  done_bits
);

    logic [width-1:0] mem [depth];

    // Payload capture on a legal completion; storage is not reset.
    always_ff @(posedge clk) begin
        if (done_en) begin
            mem[done_idx] <= done_data;
        end
    end

    assign rd_data = mem[rd_idx];

    // Slot lifecycle bits; clear wins over every other update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_bits <= '0;
            done_bits  <= '0;
        end else if (clear) begin
            alloc_bits <= '0;
            done_bits  <= '0;
        end else begin
            if (set_en) begin
                alloc_bits[set_idx] <= 1'b1;
                done_bits[set_idx]  <= 1'b0;
            end
            if (done_en) begin
                done_bits[done_idx] <= 1'b1;
            end
            if (free_en) begin
                alloc_bits[free_idx] <= 1'b0;
                done_bits[free_idx]  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_buf.sv
// Reorder buffer: in-order allocate, out-of-order complete,
// in-order retire, with flush and a sticky bad-write flag.
module rob_buf
    import rob_buf_pkg::*;
#(
    parameter int depth  = DEF_DEPTH,
    parameter int awidth = DEF_AWIDTH,
    parameter int width  = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alloc_req,
    output logic              alloc_ready,
    output logic [awidth-1:0] alloc_tag,
    input  logic              wr_en,
    input  logic [awidth-1:0] wr_tag,
    input  logic [width-1:0]  wr_data,
    output logic              ret_valid,
    input  logic              ret_ready,
    output logic [awidth-1:0] ret_tag,
    output logic [width-1:0]  ret_data,
    output logic [awidth:0]   count,
    output logic              full,
    output logic              empty,
    output logic              err_wr
);

    logic [awidth:0]  head;
    logic [awidth:0]  tail;
    logic [depth-1:0] alloc_bits;
    logic [depth-1:0] done_bits;
    logic             wr_ok;
    logic             alloc_fire;
    logic             wr_fire;
    logic             ret_fire;

    assign alloc_tag   = tail[awidth-1:0];
    assign ret_tag     = head[awidth-1:0];
    assign count       = tail - head;
    assign empty       = (head == tail);
    assign full        = (head[awidth-1:0] == tail[awidth-1:0])
                      && (head[awidth] != tail[awidth]);
    assign alloc_ready = !full;
    assign ret_valid   = !empty && done_bits[ret_tag];

    // A write is only legal into an allocated, still-pending slot.
    assign wr_ok      = alloc_bits[wr_tag] && !done_bits[wr_tag];
    assign alloc_fire = alloc_req && !full && !flush;
    assign wr_fire    = wr_en && wr_ok && !flush;
    assign ret_fire   = ret_valid && ret_ready && !flush;

    rob_store #(
        .depth  (depth),
        .awidth (awidth),
        .width  (width)
    ) u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (flush),
        .set_en     (alloc_fire),
        .set_idx    (alloc_tag),
        .done_en    (wr_fire),
        .done_idx   (wr_tag),
        .done_data  (wr_data),
        .free_en    (ret_fire),
        .free_idx   (ret_tag),
        .rd_idx     (ret_tag),
        .rd_data    (ret_data),
        .alloc_bits (alloc_bits),
        .done_bits  (done_bits)
    );

    // Head/tail advance; flush rewinds both to slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + 1'b1;
            end
            if (ret_fire) begin
                head <= head + 1'b1;
            end
        end
    end

    // Sticky bad-write flag; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_wr <= 1'b0;
        end else if (wr_en && !wr_ok && !flush) begin
            err_wr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rob_buf.sv
// Directed self-checking bench for rob_buf.
// Each step drives inputs and checks hand-computed outputs.
module tb_rob_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        alloc_req;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        wr_en;
    logic [2:0]  wr_tag;
    logic [33:0] wr_data;
    logic        ret_valid;
    logic        ret_ready;
    logic [2:0]  ret_tag;
    logic [33:0] ret_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        err_wr;

    int checks = 0;
    int errors = 0;

    rob_buf #(.depth(8), .awidth(3), .width(34)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .alloc_req   (alloc_req),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .wr_en       (wr_en),
        .wr_tag      (wr_tag),
        .wr_data     (wr_data),
        .ret_valid   (ret_valid),
        .ret_ready   (ret_ready),
        .ret_tag     (ret_tag),
        .ret_data    (ret_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .err_wr      (err_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; alloc_req = 0; wr_en = 0;
        wr_tag = 0; wr_data = 0; ret_ready = 0;
    endtask

    task automatic do_flush();
        flush = 1;
        cyc();
        flush = 0;
        #1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", alloc_ready, 1);
        chk("rst_rvalid", ret_valid, 0);
        chk("rst_atag", alloc_tag, 0);
        chk("rst_rtag", ret_tag, 0);
        chk("rst_err", err_wr, 0);
        @(negedge clk);
        rst_n = 1;

        // Fill all eight slots.
        for (int i = 0; i < 8; i++) begin
            alloc_req = 1;
            #1;
            chk("fill_tag", alloc_tag, i);
            cyc();
        end
        alloc_req = 0;
        #1;
        chk("fill_full", full, 1);
        chk("fill_ready", alloc_ready, 0);
        chk("fill_count", count, 8);
        alloc_req = 1;
        cyc();
        alloc_req = 0;
        #1;
        chk("full_blocked", count, 8);
        chk("full_noerr", err_wr, 0);
        do_flush();
        chk("flush1_empty", empty, 1);

        // Out-of-order completion, in-order retire.
        alloc_req = 1;
        cyc(); cyc(); cyc();
        alloc_req = 0;
        wr_en = 1; wr_tag = 2; wr_data = 34'hAA;
        cyc();
        chk("ooo_rv_t2", ret_valid, 0);
        wr_tag = 0; wr_data = 34'hCC;
        #1;
        chk("ooo_nofwd", ret_valid, 0);
        cyc();
        wr_en = 0;
        #1;
        chk("ooo_rv", ret_valid, 1);
        chk("ooo_rtag0", ret_tag, 0);
        chk("ooo_rdata0", ret_data, 34'hCC);

        // Illegal writes: unallocated slot and completed slot.
        wr_en = 1; wr_tag = 5; wr_data = 34'h55;
        cyc();
        chk("err_unalloc", err_wr, 1);
        wr_tag = 0; wr_data = 34'h11;
        cyc();
        wr_en = 0;
        #1;
        chk("err_sticky", err_wr, 1);
        chk("err_keepdata", ret_data, 34'hCC);
        chk("err_count", count, 3);
        cyc();
        chk("err_hold", err_wr, 1);

        ret_ready = 1;
        cyc();
        ret_ready = 0;
        #1;
        chk("ret1_tag", ret_tag, 1);
        chk("ret1_rv", ret_valid, 0);
        chk("ret1_count", count, 2);
        wr_en = 1; wr_tag = 1; wr_data = 34'hBB;
        cyc();
        wr_en = 0;
        #1;
        chk("ret1_rv2", ret_valid, 1);
        chk("ret1_data", ret_data, 34'hBB);
        ret_ready = 1;
        cyc();
        chk("ret2_tag", ret_tag, 2);
        chk("ret2_data", ret_data, 34'hAA);
        chk("ret2_rv", ret_valid, 1);
        cyc();
        ret_ready = 0;
        #1;
        chk("ret_done_empty", empty, 1);
        chk("ret_done_count", count, 0);
        chk("ret_done_rv", ret_valid, 0);

        // Full with head complete: retire fires, alloc blocked.
        do_flush();
        chk("flush2_err", err_wr, 1);
        alloc_req = 1;
        for (int i = 0; i < 8; i++) cyc();
        alloc_req = 0;
        wr_en = 1; wr_tag = 0; wr_data = 34'h3_0000_0033;
        cyc();
        wr_en = 0;
        alloc_req = 1; ret_ready = 1;
        #1;
        chk("fr_rv", ret_valid, 1);
        chk("fr_ready", alloc_ready, 0);
        chk("fr_data", ret_data, 34'h3_0000_0033);
        cyc();
        ret_ready = 0;
        #1;
        chk("fr_count7", count, 7);
        chk("fr_head", ret_tag, 1);
        chk("fr_atag", alloc_tag, 0);
        cyc();
        alloc_req = 0;
        #1;
        chk("fr_count8", count, 8);
        chk("fr_full", full, 1);

        // Twenty single-entry rounds; pointers wrap past 15.
        do_flush();
        for (int i = 0; i < 20; i++) begin
            alloc_req = 1;
            #1;
            chk("rnd_atag", alloc_tag, i % 8);
            cyc();
            alloc_req = 0;
            chk("rnd_count1", count, 1);
            wr_en = 1; wr_tag = 3'(i % 8); wr_data = 34'(i + 256);
            cyc();
            wr_en = 0;
            #1;
            chk("rnd_data", ret_data, i + 256);
            chk("rnd_rtag", ret_tag, i % 8);
            ret_ready = 1;
            cyc();
            ret_ready = 0;
            #1;
            chk("rnd_count0", count, 0);
        end

        // Flush with five live entries plus concurrent traffic.
        alloc_req = 1;
        for (int i = 0; i < 5; i++) cyc();
        alloc_req = 0;
        #1;
        chk("pre_flush_count", count, 5);
        flush = 1; alloc_req = 1;
        wr_en = 1; wr_tag = 4; wr_data = 34'h77;
        cyc();
        idle();
        #1;
        chk("fl_empty", empty, 1);
        chk("fl_count", count, 0);
        chk("fl_atag", alloc_tag, 0);
        chk("fl_err", err_wr, 1);
        chk("fl_rv", ret_valid, 0);
        alloc_req = 1;
        cyc();
        alloc_req = 0;
        #1;
        chk("fl_alloc_rv", ret_valid, 0);
        chk("fl_alloc_cnt", count, 1);

        // Asynchronous reset mid-cycle.
        #2;
        rst_n = 0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_err", err_wr, 0);
        chk("arst_atag", alloc_tag, 0);
        @(negedge clk);
        rst_n = 1;

        // Alloc and write to the same new slot: write is illegal.
        alloc_req = 1; wr_en = 1; wr_tag = 0; wr_data = 34'h99;
        cyc();
        idle();
        #1;
        chk("aw_err", err_wr, 1);
        chk("aw_count", count, 1);
        chk("aw_rv", ret_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
